display_scanner: RTL and testbench
==================================

Name: display_scanner

Overview:
- Parametrised, self-scanning multiplexer for an N-digit common-anode 7-segment display.
- Generates its own scan timing from the system clock and presents one digit at a time.
- Output is one digit's hex nibble, decimal point, LE bit and active-low anode vector, ready for the hex-to-segment decoder.
- Adds four features: double-buffered tear-free update, per-digit blink, per-digit blank, and leading-zero suppression.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 100000, clock cycles each digit is displayed (≥2).
- BLINK_BITS, 25, width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures all *_in buses into staging.
- hexs_in  in  4*DIGITS  digit nibbles; digit i = [4i+3:4i], digit 0 rightmost.
- point_in  in  DIGITS  per-digit point bit, passed through.
- les_in  in  DIGITS  per-digit LE bit, passed through.
- blank_in  in  DIGITS  1 = digit always dark.
- blink_in  in  DIGITS  1 = digit dark while blink phase = 1.
- lzs_en  in  1  enable leading-zero suppression (level, not staged).
- hex  out  4  nibble of the current digit.
- p  out  1  point bit of the current digit.
- le  out  1  LE bit of the current digit.
- an  out  DIGITS  anode select, active low, at most one bit 0.
- scan  out  clog2(DIGITS)  index of the current digit.
- upd_done  out  1  one-cycle pulse when staged data becomes visible.

Behaviour:
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1).
- Scan index: increments on tick, wraps DIGITS-1 -> 0.
- Frame boundary: tick while scan == DIGITS-1.
- Blink counter: free-running BLINK_BITS-wide counter that wraps naturally. Blink phase = its MSB.
- Staging registers: loaded on the cycle load=1; pending <= 1. A second load while pending overwrites staging (last wins).
- Transfer: at a frame boundary with pending=1, active <= staging, pending <= 0, upd_done = 1 on the next cycle only.
- Load coinciding with a frame boundary: the transfer uses the old staging contents; the new data is captured and pending stays 1 until the next boundary.
- Leading-zero suppression (lzs_en=1): digit i≥1 is suppressed iff active nibbles i..DIGITS-1 are all 0. Digit 0 is never suppressed. It is evaluated on active data each cycle.
- Dark condition for the current digit: blank | (blink & phase) | suppressed. A dark digit drives an = all ones.
- Lit digit: an has 0 at bit scan only.
- hex/p/le always come from the active digit, regardless of the dark condition.
- All outputs are registered: outputs reflect the scan index one cycle after it changes (1-cycle latency). Steady-state digit dwell = SCAN_DIV cycles.
- Reset: prescaler, scan, blink counter, staging, active, pending = 0. Outputs: hex=0, p=0, le=0, an=all ones, scan=0, upd_done=0.
- rst mid-frame or with pending=1 discards staged data; no upd_done is produced.
- Power-on display shows nothing meaningful until the first load and transfer (active = 0).

Test Plan:
- DIGITS=4, SCAN_DIV=4, rst 2 cycles, load hexs_in=16'h1234, point_in=4'b0101, les_in=4'hF -> upd_done pulses after the first frame boundary (scan 3->0). Then an cycles 1110,1101,1011,0111 with 4 cycles each; hex follows 4,3,2,1; p follows 1,0,1,0.
- Tear-free update: load 16'hAAAA at scan=1 mid-frame -> hex stays on the old values through scan=3; 'A' appears only from scan=0; exactly one upd_done.
- Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is ever displayed; one upd_done.
- lzs_en=1, active 16'h0050 -> digits 3 and 2 dark (an=1111 during their slots), digits 1 and 0 lit. Active 16'h0000 -> only digit 0 lit, showing 0.
- BLINK_BITS=4, blink_in=4'b0001, blank_in=4'b1000 -> digit 0 dark exactly when blink counter ≥ 8, lit otherwise; digit 3 always dark; digits 1–2 unaffected.
- rst asserted at scan=2 with pending=1 -> next cycle an=1111, scan=0, hex=0; no upd_done; subsequent frames show 0000.

Source files
------------

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - self-scanning N-digit 7-segment multiplexer with
// double-buffered update, per-digit blink/blank and leading-zero suppression.
module display_scanner #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_BITS = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        hexs_in,
  input  logic [DIGITS-1:0]          point_in,
  input  logic [DIGITS-1:0]          les_in,
  input  logic [DIGITS-1:0]          blank_in,
  input  logic [DIGITS-1:0]          blink_in,
  input  logic                       lzs_en,
  output logic [3:0]                 hex,
  output logic                       p,
  output logic                       le,
  output logic [DIGITS-1:0]          an,
  output logic [$clog2(DIGITS)-1:0]  scan,
  output logic                       upd_done
);

  localparam int SW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]         PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]         PRESC_ONE = PW'(1);
  localparam logic [SW-1:0]         SCAN_MAX  = SW'(DIGITS - 1);
  localparam logic [SW-1:0]         SCAN_ONE  = SW'(1);
  localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);

  logic [PW-1:0]         r_presc;
  logic [SW-1:0]         r_scan;
  logic [BLINK_BITS-1:0] r_blink;
  logic                  r_pending;

  logic [4*DIGITS-1:0]   r_stg_hex;
  logic [DIGITS-1:0]     r_stg_p;
  logic [DIGITS-1:0]     r_stg_le;
  logic [DIGITS-1:0]     r_stg_blank;
  logic [DIGITS-1:0]     r_stg_blink;

  logic [4*DIGITS-1:0]   r_act_hex;
  logic [DIGITS-1:0]     r_act_p;
  logic [DIGITS-1:0]     r_act_le;
  logic [DIGITS-1:0]     r_act_blank;
  logic [DIGITS-1:0]     r_act_blink;

  logic                  w_tick;
  logic                  w_frame;
  logic                  w_xfer;
  logic                  w_zero_run;
  logic [DIGITS-1:0]     w_supp;
  logic                  w_dark;
  logic [DIGITS-1:0]     w_an;

  assign w_tick  = (r_presc == PRESC_MAX);
  assign w_frame = w_tick && (r_scan == SCAN_MAX);
  assign w_xfer  = w_frame && r_pending;

  // Walk down from the most significant digit; a digit is suppressed while
  // every nibble from it upward is zero. Digit 0 always stays visible.
  always_comb begin
    w_supp     = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_act_hex[4*i +: 4] == 4'h0);
      w_supp[i]  = lzs_en & w_zero_run;
    end
  end

  assign w_dark = r_act_blank[r_scan]
                | (r_act_blink[r_scan] & r_blink[BLINK_BITS-1])
                | w_supp[r_scan];

  always_comb begin
    w_an = '1;
    if (!w_dark) w_an[r_scan] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_scan      <= '0;
      r_blink     <= '0;
      r_pending   <= 1'b0;
      r_stg_hex   <= '0;
      r_stg_p     <= '0;
      r_stg_le    <= '0;
      r_stg_blank <= '0;
      r_stg_blink <= '0;
      r_act_hex   <= '0;
      r_act_p     <= '0;
      r_act_le    <= '0;
      r_act_blank <= '0;
      r_act_blink <= '0;
      hex         <= 4'h0;
      p           <= 1'b0;
      le          <= 1'b0;
      an          <= '1;
      scan        <= '0;
      upd_done    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
      if (w_tick) r_scan <= (r_scan == SCAN_MAX) ? '0 : r_scan + SCAN_ONE;
      r_blink <= r_blink + BLINK_ONE;

      // Transfer takes the pre-edge staging, so a coinciding load survives
      // in staging and stays pending for the next frame.
      if (w_xfer) begin
        r_act_hex   <= r_stg_hex;
        r_act_p     <= r_stg_p;
        r_act_le    <= r_stg_le;
        r_act_blank <= r_stg_blank;
        r_act_blink <= r_stg_blink;
      end

      if (load) begin
        r_stg_hex   <= hexs_in;
        r_stg_p     <= point_in;
        r_stg_le    <= les_in;
        r_stg_blank <= blank_in;
        r_stg_blink <= blink_in;
        r_pending   <= 1'b1;
      end else if (w_xfer) begin
        r_pending   <= 1'b0;
      end

      upd_done <= w_xfer;
      hex      <= r_act_hex[{r_scan, 2'b00} +: 4];
      p        <= r_act_p[r_scan];
      le       <= r_act_le[r_scan];
      an       <= w_an;
      scan     <= r_scan;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized and directed bench for display_scanner
// against a time-indexed behavioural model.
module tb_display_scanner;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] hexs_in;
  logic [3:0]  point_in;
  logic [3:0]  les_in;
  logic [3:0]  blank_in;
  logic [3:0]  blink_in;
  logic        lzs_en;
  logic [3:0]  hex;
  logic        p;
  logic        le;
  logic [3:0]  an;
  logic [1:0]  scan;
  logic        upd_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_upd    = 0;

  // Model: t counts cycles since reset, so slot, prescaler and blink phase
  // all follow from plain division.
  int          t;
  logic [15:0] m_stg_hex, m_act_hex;
  logic [3:0]  m_stg_p, m_stg_le, m_stg_bk, m_stg_bl;
  logic [3:0]  m_act_p, m_act_le, m_act_bk, m_act_bl;
  logic        m_pend;

  display_scanner #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_BITS(BB)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .hexs_in  (hexs_in),
    .point_in (point_in),
    .les_in   (les_in),
    .blank_in (blank_in),
    .blink_in (blink_in),
    .lzs_en   (lzs_en),
    .hex      (hex),
    .p        (p),
    .le       (le),
    .an       (an),
    .scan     (scan),
    .upd_done (upd_done)
  );

  always #5 clk = ~clk;

  function automatic int m_sc();
    return (t / SD) % D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_stg_hex = '0; m_stg_p = '0; m_stg_le = '0; m_stg_bk = '0; m_stg_bl = '0;
    m_act_hex = '0; m_act_p = '0; m_act_le = '0; m_act_bk = '0; m_act_bl = '0;
    m_pend = 1'b0;
  endtask

  task automatic step();
    int         sc;
    logic [3:0] e_hex, e_an;
    logic       e_p, e_le, e_upd, dark, supp;
    logic [1:0] e_scan;
    e_hex = 4'h0; e_an = 4'hF; e_p = 1'b0; e_le = 1'b0; e_upd = 1'b0; e_scan = 2'd0;
    if (!rst) begin
      sc     = m_sc();
      e_hex  = 4'((m_act_hex >> (4 * sc)) & 16'hF);
      e_p    = m_act_p[sc];
      e_le   = m_act_le[sc];
      supp   = lzs_en && (sc >= 1) && ((m_act_hex >> (4 * sc)) == 16'h0);
      dark   = m_act_bk[sc] || (m_act_bl[sc] && ((t % 16) >= 8)) || supp;
      e_an   = dark ? 4'hF : (4'hF ^ (4'b0001 << sc));
      e_scan = 2'(sc);
      e_upd  = ((t % SD) == SD - 1) && (sc == D - 1) && m_pend;
    end
    @(posedge clk);
    #1;
    chk("hex", 32'(hex), 32'(e_hex));
    chk("p", 32'(p), 32'(e_p));
    chk("le", 32'(le), 32'(e_le));
    chk("an", 32'(an), 32'(e_an));
    chk("scan", 32'(scan), 32'(e_scan));
    chk("upd_done", 32'(upd_done), 32'(e_upd));
    if (upd_done) n_upd++;
    if (rst) begin
      model_reset();
    end else begin
      if (e_upd) begin
        m_act_hex = m_stg_hex; m_act_p = m_stg_p; m_act_le = m_stg_le;
        m_act_bk = m_stg_bk; m_act_bl = m_stg_bl;
      end
      if (load) begin
        m_stg_hex = hexs_in; m_stg_p = point_in; m_stg_le = les_in;
        m_stg_bk = blank_in; m_stg_bl = blink_in;
        m_pend = 1'b1;
      end else if (e_upd) begin
        m_pend = 1'b0;
      end
      t++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_slot(input int target);
    int k;
    k = 0;
    while (!(m_sc() == target && (t % SD) == 0) && k < 64) begin
      step();
      k++;
    end
    if (!(m_sc() == target && (t % SD) == 0)) chk("wait_slot", 32'(m_sc()), 32'(target));
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] pt, input logic [3:0] l,
                         input logic [3:0] bk, input logic [3:0] bl);
    hexs_in = h; point_in = pt; les_in = l; blank_in = bk; blink_in = bl;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; hexs_in = '0; point_in = '0; les_in = '0;
    blank_in = '0; blink_in = '0; lzs_en = 1'b0;
    model_reset();
    run(2);
    rst = 1'b0;

    n_upd = 0;
    do_load(16'h1234, 4'b0101, 4'hF, 4'h0, 4'h0);
    run(40);
    chk("upd_cnt_first", 32'(n_upd), 32'd1);

    wait_slot(1);
    n_upd = 0;
    do_load(16'hAAAA, 4'h0, 4'h0, 4'h0, 4'h0);
    run(32);
    chk("upd_cnt_tearfree", 32'(n_upd), 32'd1);

    wait_slot(0);
    n_upd = 0;
    do_load(16'h1111, 4'h0, 4'h0, 4'h0, 4'h0);
    run(2);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0, 4'h0);
    run(32);
    chk("upd_cnt_lastwins", 32'(n_upd), 32'd1);

    lzs_en = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0, 4'h0, 4'h0);
    run(40);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0, 4'h0);
    run(40);
    lzs_en = 1'b0;

    do_load(16'h1234, 4'h0, 4'h0, 4'b1000, 4'b0001);
    run(64);

    wait_slot(1);
    do_load(16'hBEEF, 4'hF, 4'hF, 4'h0, 4'h0);
    wait_slot(2);
    n_upd = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);
    chk("upd_cnt_rst", 32'(n_upd), 32'd0);

    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 7) == 0);
      hexs_in  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) hexs_in = hexs_in & 16'h00FF;
      point_in = 4'($urandom);
      les_in   = 4'($urandom);
      blank_in = 4'($urandom) & 4'($urandom);
      blink_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lzs_en = ~lzs_en;
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
